// File: rtl/hazard_sched_unit.sv
// hazard_sched_unit
// Pipeline hazard controller and scheduler for the five-stage RV32 core.
//
// Purpose:
//   - Operand forwarding selects for the execute stage (M priority over W).
//   - Load-use stall and taken-branch flush generation.
//   - Holds the execute stage for MD_LAT cycles when a multi-cycle MUL/DIV
//     op is in E. This uses a three-state FSM (IDLE, MD_BUSY, MD_DONE)
//     and a down-counter.
//
// Ports:
//   clk, rst                   clock, synchronous active-low reset
//   Rs1_D, Rs2_D               source registers of the instruction in D
//   Rs1_E, Rs2_E               source registers of the instruction in E
//   RD_E, RD_M, RD_W           destination registers in E/M/W
//   RegWriteM, RegWriteW       register write enables in M/W
//   ResultSrcE                 instruction in E is a load
//   PCSrcE                     branch/jump taken, resolved in E
//   MulDivStartE               MUL/DIV in E (level, held while in E)
//   ForwardA_E, ForwardB_E     00 = RD1/RD2_E, 10 = ALU_ResultM, 01 = ResultW
//   StallF, StallD, StallE     hold PC, IF/ID, ID/EX
//   FlushD, FlushE             clear IF/ID, ID/EX
//   MulDivBusy                 FSM is in MD_BUSY
//   MulDivDone                 one-cycle pulse as the MUL/DIV op leaves E
//
// Optional feature (macro HAZARD_PERF_CNT_EN):
//   perf_stall_cycles, perf_flush_count, perf_md_ops  32-bit wrapping counters
module hazard_sched_unit #(
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] Rs1_D,
  input  logic [4:0] Rs2_D,
  input  logic [4:0] Rs1_E,
  input  logic [4:0] Rs2_E,
  input  logic [4:0] RD_E,
  input  logic [4:0] RD_M,
  input  logic [4:0] RD_W,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       ResultSrcE,
  input  logic       PCSrcE,
  input  logic       MulDivStartE,
  output logic [1:0] ForwardA_E,
  output logic [1:0] ForwardB_E,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushD,
  output logic       FlushE,
  output logic       MulDivBusy,
  output logic       MulDivDone
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flush_count,
  output logic [31:0] perf_md_ops
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } state_t;

  // The start cycle is itself a stall cycle, so the counter covers the
  // remaining MD_LAT-1 busy cycles, ending when it reads zero.
  localparam logic [CNT_W-1:0] CNT_LOAD = (MD_LAT > 1) ? CNT_W'(MD_LAT - 2) : '0;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             md_stall;
  logic             md_busy;
  logic             md_done;
  logic             lw_stall;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic       wr_m,
                                         input logic [4:0] rd_m,
                                         input logic       wr_w,
                                         input logic [4:0] rd_w);
    logic [1:0] sel;
    sel = 2'b00;
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = 2'b10;
    end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    md_stall = 1'b0;
    md_busy  = 1'b0;
    md_done  = 1'b0;
    case (state_q)
      IDLE: begin
        // A taken branch squashes the op in E, so it never starts.
        if (MulDivStartE && !PCSrcE) begin
          md_stall = 1'b1;
          if (MD_LAT > 1) begin
            cnt_d   = CNT_LOAD;
            state_d = MD_BUSY;
          end else begin
            state_d = MD_DONE;
          end
        end
      end
      MD_BUSY: begin
        md_stall = 1'b1;
        md_busy  = 1'b1;
        if (cnt_q == '0) begin
          state_d = MD_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      MD_DONE: begin
        // The finished op is still in E this cycle; its start level is
        // deliberately ignored so it does not launch a second time.
        md_done = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign lw_stall = ResultSrcE && (RD_E != 5'd0) && ((RD_E == Rs1_D) || (RD_E == Rs2_D));

  // Every output is held at zero while reset is asserted.
  always_comb begin
    ForwardA_E = 2'b00;
    ForwardB_E = 2'b00;
    StallF     = 1'b0;
    StallD     = 1'b0;
    StallE     = 1'b0;
    FlushD     = 1'b0;
    FlushE     = 1'b0;
    MulDivBusy = 1'b0;
    MulDivDone = 1'b0;
    if (rst) begin
      ForwardA_E = fwd_sel(Rs1_E, RegWriteM, RD_M, RegWriteW, RD_W);
      ForwardB_E = fwd_sel(Rs2_E, RegWriteM, RD_M, RegWriteW, RD_W);
      StallE     = md_stall;
      StallF     = md_stall | lw_stall;
      StallD     = md_stall | lw_stall;
      // A held E stage must not be cleared underneath the MUL/DIV op.
      FlushD     = PCSrcE & ~md_stall;
      FlushE     = (PCSrcE | lw_stall) & ~md_stall;
      MulDivBusy = md_busy;
      MulDivDone = md_done;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_stall_cycles <= '0;
      perf_flush_count  <= '0;
      perf_md_ops       <= '0;
    end else begin
      perf_stall_cycles <= perf_stall_cycles + {31'd0, StallF};
      perf_flush_count  <= perf_flush_count + {31'd0, (FlushD | FlushE)};
      perf_md_ops       <= perf_md_ops + {31'd0, MulDivDone};
    end
  end
`endif

endmodule

// File: tb/tb_hazard_sched_unit.sv
// Testbench for hazard_sched_unit: two instances (MD_LAT=4 and MD_LAT=1)
// sharing one stimulus stream, compared each cycle against a reference
// model that tracks MUL/DIV occupancy as "age of the op in E".
module tb_hazard_sched_unit;

  logic       clk;
  logic       rst;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic       reg_write_m, reg_write_w, result_src_e, pc_src_e, md_start_e;

  logic [1:0] fa4, fb4, fa1, fb1;
  logic       sf4, sd4, se4, fd4, fe4, bz4, dn4;
  logic       sf1, sd1, se1, fd1, fe1, bz1, dn1;
  logic [10:0] obs4, obs1;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] ps4, pf4, pm4, ps1, pf1, pm1;
  logic [31:0] mps4, mpf4, mpm4, mps1, mpf1, mpm1;
  bit          perf_valid;
`endif

  int compared;
  int mismatched;
  int age4, age1;
  int n_se4, n_bz4, n_dn4, n_se1, n_dn1;

  hazard_sched_unit #(.MD_LAT(4), .CNT_W(4)) u_lat4 (
    .clk(clk), .rst(rst),
    .Rs1_D(rs1_d), .Rs2_D(rs2_d), .Rs1_E(rs1_e), .Rs2_E(rs2_e),
    .RD_E(rd_e), .RD_M(rd_m), .RD_W(rd_w),
    .RegWriteM(reg_write_m), .RegWriteW(reg_write_w),
    .ResultSrcE(result_src_e), .PCSrcE(pc_src_e), .MulDivStartE(md_start_e),
    .ForwardA_E(fa4), .ForwardB_E(fb4),
    .StallF(sf4), .StallD(sd4), .StallE(se4),
    .FlushD(fd4), .FlushE(fe4),
    .MulDivBusy(bz4), .MulDivDone(dn4)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_stall_cycles(ps4), .perf_flush_count(pf4), .perf_md_ops(pm4)
`endif
  );

  hazard_sched_unit #(.MD_LAT(1), .CNT_W(4)) u_lat1 (
    .clk(clk), .rst(rst),
    .Rs1_D(rs1_d), .Rs2_D(rs2_d), .Rs1_E(rs1_e), .Rs2_E(rs2_e),
    .RD_E(rd_e), .RD_M(rd_m), .RD_W(rd_w),
    .RegWriteM(reg_write_m), .RegWriteW(reg_write_w),
    .ResultSrcE(result_src_e), .PCSrcE(pc_src_e), .MulDivStartE(md_start_e),
    .ForwardA_E(fa1), .ForwardB_E(fb1),
    .StallF(sf1), .StallD(sd1), .StallE(se1),
    .FlushD(fd1), .FlushE(fe1),
    .MulDivBusy(bz1), .MulDivDone(dn1)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_stall_cycles(ps1), .perf_flush_count(pf1), .perf_md_ops(pm1)
`endif
  );

  assign obs4 = {fa4, fb4, sf4, sd4, se4, fd4, fe4, bz4, dn4};
  assign obs1 = {fa1, fb1, sf1, sd1, se1, fd1, fe1, bz1, dn1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
    if (reg_write_m && rd_m != 5'd0 && rd_m == rs) return 2'b10;
    if (reg_write_w && rd_w != 5'd0 && rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  // age < 0: no op in flight (a start may happen this cycle);
  // age 1..lat-1: still holding E; age == lat: op leaves E this cycle.
  function automatic logic [10:0] expect_vec(input int lat, input int age);
    logic md, bz, dn, lw;
    if (!rst) return 11'd0;
    md = (age < 0) ? (md_start_e && !pc_src_e) : (age < lat);
    bz = (age >= 1) && (age < lat);
    dn = (age == lat);
    lw = result_src_e && rd_e != 5'd0 && (rd_e == rs1_d || rd_e == rs2_d);
    return {fwd_ref(rs1_e), fwd_ref(rs2_e), md | lw, md | lw, md,
            pc_src_e & ~md, (pc_src_e | lw) & ~md, bz, dn};
  endfunction

  function automatic int next_age(input int lat, input int age);
    if (!rst) return -1;
    if (age < 0) return (md_start_e && !pc_src_e) ? 1 : -1;
    if (age < lat) return age + 1;
    return -1;
  endfunction

  task automatic cycle(input string tag);
    logic [10:0] e4, e1;
    #1;
    e4 = expect_vec(4, age4);
    e1 = expect_vec(1, age1);
    chk({tag, "/lat4"}, 32'(obs4), 32'(e4));
    chk({tag, "/lat1"}, 32'(obs1), 32'(e1));
    n_se4 += int'(se4); n_bz4 += int'(bz4); n_dn4 += int'(dn4);
    n_se1 += int'(se1); n_dn1 += int'(dn1);
`ifdef HAZARD_PERF_CNT_EN
    if (perf_valid) begin
      chk({tag, "/perf_stall4"}, ps4, mps4);
      chk({tag, "/perf_flush4"}, pf4, mpf4);
      chk({tag, "/perf_md4"}, pm4, mpm4);
      chk({tag, "/perf_stall1"}, ps1, mps1);
      chk({tag, "/perf_flush1"}, pf1, mpf1);
      chk({tag, "/perf_md1"}, pm1, mpm1);
    end
`endif
    @(posedge clk);
`ifdef HAZARD_PERF_CNT_EN
    if (!rst) begin
      mps4 = 0; mpf4 = 0; mpm4 = 0; mps1 = 0; mpf1 = 0; mpm1 = 0;
      perf_valid = 1'b1;
    end else begin
      mps4 += 32'(e4[6]); mpf4 += 32'(e4[3] | e4[2]); mpm4 += 32'(e4[0]);
      mps1 += 32'(e1[6]); mpf1 += 32'(e1[3] | e1[2]); mpm1 += 32'(e1[0]);
    end
`endif
    age4 = next_age(4, age4);
    age1 = next_age(1, age1);
    #1;
  endtask

  task automatic clear_tallies();
    n_se4 = 0; n_bz4 = 0; n_dn4 = 0; n_se1 = 0; n_dn1 = 0;
  endtask

  task automatic idle_inputs();
    rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
    reg_write_m = 0; reg_write_w = 0; result_src_e = 0; pc_src_e = 0; md_start_e = 0;
  endtask

  initial begin
    compared = 0; mismatched = 0; age4 = -1; age1 = -1;
    clear_tallies();
`ifdef HAZARD_PERF_CNT_EN
    perf_valid = 1'b0;
    mps4 = 0; mpf4 = 0; mpm4 = 0; mps1 = 0; mpf1 = 0; mpm1 = 0;
`endif
    rst = 1'b0;
    idle_inputs();
    #2;

    // Reset: all outputs zero even with hazards presented.
    cycle("reset0");
    pc_src_e = 1; md_start_e = 1; result_src_e = 1; rd_e = 3; rs1_d = 3;
    cycle("reset_gated");
    chk("reset_state", 32'(obs4), 32'd0);
    idle_inputs();
    rst = 1'b1;
    cycle("idle");

    // Forward priority M over W, then W alone.
    rd_m = 5; rd_w = 5; reg_write_m = 1; reg_write_w = 1; rs1_e = 5; rs2_e = 0;
    cycle("fwd_m_prio");
    chk("fwdA_m", 32'(fa4), 32'(2'b10));
    chk("fwdB_none", 32'(fb4), 32'(2'b00));
    reg_write_m = 0;
    cycle("fwd_w");
    chk("fwdA_w", 32'(fa4), 32'(2'b01));

    // x0 never forwards or stalls.
    idle_inputs();
    rd_m = 0; reg_write_m = 1; rs1_e = 0;
    cycle("x0_fwd");
    chk("x0_fwdA", 32'(fa4), 32'd0);
    idle_inputs();
    rd_e = 0; result_src_e = 1; rs1_d = 0;
    cycle("x0_lw");
    chk("x0_nostall", 32'(sf4), 32'd0);

    // Load-use hazard on Rs2.
    idle_inputs();
    result_src_e = 1; rd_e = 7; rs2_d = 7; rs1_d = 2;
    cycle("load_use");
    chk("lw_vec", 32'({sf4, sd4, se4, fd4, fe4}), 32'(5'b11001));

    // Taken branch, then branch together with a MUL/DIV start.
    idle_inputs();
    pc_src_e = 1;
    cycle("branch");
    chk("br_vec", 32'({sf4, sd4, se4, fd4, fe4}), 32'(5'b00011));
    md_start_e = 1;
    cycle("branch_md");
    idle_inputs();
    cycle("after_branch_md");
    chk("br_md_nobusy", 32'({bz4, se4, bz1, se1}), 32'd0);

    // MUL/DIV held in E for five cycles.
    clear_tallies();
    md_start_e = 1;
    for (int i = 0; i < 5; i++) cycle("md_hold");
    chk("md4_stall_cycles", 32'(n_se4), 32'd4);
    chk("md4_busy_cycles", 32'(n_bz4), 32'd3);
    chk("md4_done_pulses", 32'(n_dn4), 32'd1);
    chk("md1_stall_cycles", 32'(n_se1), 32'd3);
    chk("md1_done_pulses", 32'(n_dn1), 32'd2);
    md_start_e = 0;
    cycle("md_after");
    chk("md4_idle", 32'({se4, bz4, dn4}), 32'd0);

    // Reset in the second MD_BUSY cycle aborts the op.
    md_start_e = 1;
    cycle("md_start");
    cycle("md_busy1");
    rst = 1'b0;
    cycle("rst_mid");
    chk("rst_mid_zero", 32'(obs4), 32'd0);
    rst = 1'b1; md_start_e = 0;
    clear_tallies();
    cycle("post_rst");
    cycle("post_rst2");
    chk("post_rst_nodone", 32'(n_dn4 + n_se4), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_zero", ps4 | pf4 | pm4, 32'd0);
`endif

    // Randomized traffic with small register numbers to force collisions.
    for (int i = 0; i < 400; i++) begin
      rst          = ($urandom_range(0, 39) != 0);
      rs1_d        = 5'($urandom_range(0, 3));
      rs2_d        = 5'($urandom_range(0, 3));
      rs1_e        = 5'($urandom_range(0, 3));
      rs2_e        = 5'($urandom_range(0, 3));
      rd_e         = 5'($urandom_range(0, 3));
      rd_m         = 5'($urandom_range(0, 3));
      rd_w         = 5'($urandom_range(0, 3));
      reg_write_m  = 1'($urandom_range(0, 1));
      reg_write_w  = 1'($urandom_range(0, 1));
      result_src_e = 1'($urandom_range(0, 1));
      pc_src_e     = ($urandom_range(0, 4) == 0);
      md_start_e   = ($urandom_range(0, 2) == 0);
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
